// File: rtl/cnt_down_timer.sv
// cnt_down_timer: prescaled down-counting timer with one-shot/periodic modes and sticky irq
module cnt_down_timer #(
  parameter int W  = 16,
  parameter int PW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          mode_i,
  input  logic [W-1:0]  ld_val_i,
  input  logic [PW-1:0] psc_i,
  input  logic          irq_clr_i,
  output logic [W-1:0]  cnt_o,
  output logic          busy_o,
  output logic          tc_o,
  output logic          irq_o
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d, rld_q, rld_d;
  logic [PW-1:0] psc_cnt_q, psc_cnt_d, psc_rld_q, psc_rld_d;
  logic          mode_q, mode_d, tc_q, tc_d, irq_q, irq_d;
  logic          tick;
  assign tick = (state_q == RUN) && (psc_cnt_q == '0);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rld_q     <= '0;
      psc_cnt_q <= '0;
      psc_rld_q <= '0;
      mode_q    <= 1'b0;
      tc_q      <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rld_q     <= rld_d;
      psc_cnt_q <= psc_cnt_d;
      psc_rld_q <= psc_rld_d;
      mode_q    <= mode_d;
      tc_q      <= tc_d;
      irq_q     <= irq_d;
    end
  end
  // terminal count replaces the decrement, so cnt never wraps below zero
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rld_d     = rld_q;
    psc_cnt_d = psc_cnt_q;
    psc_rld_d = psc_rld_q;
    mode_d    = mode_q;
    tc_d      = 1'b0;
    irq_d     = irq_q & ~irq_clr_i;
    if (stop_i) begin
      state_d   = IDLE;
      psc_cnt_d = '0;
    end else if (start_i) begin
      state_d   = RUN;
      cnt_d     = ld_val_i;
      rld_d     = ld_val_i;
      psc_cnt_d = psc_i;
      psc_rld_d = psc_i;
      mode_d    = mode_i;
    end else if (tick) begin
      psc_cnt_d = psc_rld_q;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - W'(1);
      end else begin
        tc_d    = 1'b1;
        irq_d   = 1'b1;
        cnt_d   = mode_q ? rld_q : '0;
        state_d = mode_q ? RUN : IDLE;
      end
    end else if (state_q == RUN) begin
      psc_cnt_d = psc_cnt_q - PW'(1);
    end
  end
  assign cnt_o  = cnt_q;
  assign busy_o = (state_q == RUN);
  assign tc_o   = tc_q;
  assign irq_o  = irq_q;
endmodule
